// File: rtl/radar_sweep_scheduler.sv
// rtl/radar_sweep_scheduler.sv - ping-pong servo sweep and ultrasonic measurement sequencer
module radar_sweep_scheduler #(
    parameter int N_STEPS        = 19,
    parameter int STEP_DEG       = 10,
    parameter int SETTLE_CYCLES  = 1000000,
    parameter int INIT_HOLD      = 100,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       meas_done,
    input  logic [8:0] meas_dist,
    output logic       meas_init,
    output logic [7:0] angle,
    output logic       sweep_dir,
    output logic       busy,
    output logic       res_valid,
    output logic [7:0] res_angle,
    output logic [8:0] res_dist,
    output logic       res_timeout
);

    localparam int IW = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_STEPS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_TRIG   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_REPORT = 3'd4;
    localparam logic [2:0] S_STEP   = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d, idx_step;
    logic          dir_q, dir_d, dir_step;
    logic [7:0]    angle_q, angle_d;
    logic          init_q, init_d;
    logic          rv_q, rv_d;
    logic [7:0]    rangle_q, rangle_d;
    logic [8:0]    rdist_q, rdist_d;
    logic          rto_q, rto_d;
    logic [2:0]    sync_q, sync_d;
    logic          done_rise;
    logic [15:0]   angle_prod;

    // sync_q[1] is the synchronised level, sync_q[2] its previous value
    assign sync_d    = {sync_q[1:0], meas_done};
    assign done_rise = sync_q[1] & ~sync_q[2];

    // Endpoints reverse direction so each end is visited once per turnaround
    always_comb begin
        idx_step = idx_q;
        dir_step = dir_q;
        if (N_STEPS > 1) begin
            if (dir_q && idx_q == LAST_IDX) begin
                dir_step = 1'b0;
                idx_step = idx_q - 1'b1;
            end else if (!dir_q && idx_q == '0) begin
                dir_step = 1'b1;
                idx_step = IW'(1);
            end else if (dir_q) begin
                idx_step = idx_q + 1'b1;
            end else begin
                idx_step = idx_q - 1'b1;
            end
        end
    end

    assign angle_prod = 16'(idx_step) * 16'(STEP_DEG);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dir_d    = dir_q;
        angle_d  = angle_q;
        init_d   = init_q;
        rv_d     = 1'b0;
        rangle_d = rangle_q;
        rdist_d  = rdist_q;
        rto_d    = rto_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == 32'(SETTLE_CYCLES - 1)) begin
                    state_d = S_TRIG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_TRIG: begin
                if (cnt_q == 32'(INIT_HOLD)) begin
                    init_d  = 1'b0;
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    init_d = 1'b1;
                    cnt_d  = cnt_q + 32'd1;
                end
            end
            S_WAIT: begin
                // A done edge on the final timeout cycle still reports the distance
                if (done_rise) begin
                    state_d  = S_REPORT;
                    rdist_d  = meas_dist;
                    rto_d    = 1'b0;
                    rangle_d = angle_q;
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = S_REPORT;
                    rdist_d  = 9'h1FF;
                    rto_d    = 1'b1;
                    rangle_d = angle_q;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_REPORT: begin
                rv_d    = 1'b1;
                state_d = S_STEP;
            end
            S_STEP: begin
                idx_d   = idx_step;
                dir_d   = dir_step;
                angle_d = angle_prod[7:0];
                cnt_d   = '0;
                state_d = enable ? S_SETTLE : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                init_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            dir_q    <= 1'b1;
            angle_q  <= '0;
            init_q   <= 1'b0;
            rv_q     <= 1'b0;
            rangle_q <= '0;
            rdist_q  <= '0;
            rto_q    <= 1'b0;
            sync_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dir_q    <= dir_d;
            angle_q  <= angle_d;
            init_q   <= init_d;
            rv_q     <= rv_d;
            rangle_q <= rangle_d;
            rdist_q  <= rdist_d;
            rto_q    <= rto_d;
            sync_q   <= sync_d;
        end
    end

    assign meas_init   = init_q;
    assign angle       = angle_q;
    assign sweep_dir   = dir_q;
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = rv_q;
    assign res_angle   = rangle_q;
    assign res_dist    = rdist_q;
    assign res_timeout = rto_q;

endmodule

// File: doc/radar_sweep_scheduler.md
Name: radar_sweep_scheduler

Overview:
- Sequences the radar front end: steps the servo angle across a ping-pong sweep and, at each position, waits for the servo to settle.
- Fires one ultrasonic measurement, collects the distance or a timeout, and publishes a tagged result (angle, distance) to the display/logging side.
- Sits between the ultrasonic ranging block (drives its init, consumes its done/dist) and the servo PWM generator (drives its angle).

Parameters:
- N_STEPS, 19, number of sweep positions; angle = index*STEP_DEG; (N_STEPS-1)*STEP_DEG must be <= 180.
- STEP_DEG, 10, degrees between adjacent positions.
- SETTLE_CYCLES, 1000000, clk cycles waited after an angle change before triggering (20 ms at 50 MHz).
- INIT_HOLD, 100, clk cycles meas_init is held high (2 us; spans >= 2 periods of the sensor's 1 MHz tick).
- TIMEOUT_CYCLES, 1500000, clk cycles allowed from meas_init falling to done rising (30 ms).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- enable  in  1  level; 1 = run sweep
- meas_done  in  1  done level from ranging block (slower domain, synchronised here)
- meas_dist  in  9  distance in cm from ranging block, stable while meas_done=1
- meas_init  out  1  start pulse to ranging block
- angle  out  8  commanded servo angle, degrees
- sweep_dir  out  1  1 = increasing angle, 0 = decreasing
- busy  out  1  1 whenever state != IDLE
- res_valid  out  1  one-cycle strobe, result fields valid
- res_angle  out  8  angle at which result was taken
- res_dist  out  9  distance in cm; 9'h1FF on timeout
- res_timeout  out  1  1 = result is a timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE; index=0; angle=0; sweep_dir=1; meas_init=0; res_valid=0; res_angle=0; res_dist=0; res_timeout=0; busy=0; all counters and done synchronisers cleared. Takes effect mid-operation immediately; no measurement completes.
- meas_done passes through a 2-flop synchroniser; done_rise = synced & ~synced_prev.
- States:
  - IDLE: if enable -> SETTLE (counter cleared).
  - SETTLE: count SETTLE_CYCLES, then -> TRIG.
  - TRIG: meas_init=1 for exactly INIT_HOLD cycles, then meas_init=0 -> WAIT (timeout counter cleared).
  - WAIT: done_rise -> REPORT with res_dist=meas_dist, res_timeout=0. Counter reaching TIMEOUT_CYCLES -> REPORT with res_dist=9'h1FF, res_timeout=1. If both occur the same cycle, the done result wins. done_rise while in TRIG or SETTLE is ignored.
  - REPORT: res_valid=1 for one cycle; res_angle=angle; res_dist and res_timeout hold until the next REPORT -> STEP.
  - STEP: advance index, then -> SETTLE if enable, else -> IDLE.
- Latency: res_valid is asserted 1 cycle after done_rise is detected, i.e. 3-4 clk after meas_done rises.
- Sweep index (ping-pong):
  - If dir=1 and index=N_STEPS-1: dir<=0, index<=index-1. If dir=0 and index=0: dir<=1, index<=1. Otherwise index +/- 1.
  - Endpoints are measured once per turnaround.
  - N_STEPS=1: index stays 0, dir stays 1.
- angle = index*STEP_DEG, registered; it updates in STEP, so SETTLE always follows an angle change.
- enable is sampled only in IDLE and STEP. Dropping it mid-measurement lets the current measurement finish, report and step, then idle. The angle is left at the advanced position, and the next enable resumes from there.
- No input back-pressure: the result consumer must accept res_valid unconditionally.

Test Plan (overrides: N_STEPS=3, STEP_DEG=90, SETTLE_CYCLES=10, INIT_HOLD=4, TIMEOUT_CYCLES=200):
1. Hold rst_n=0 with enable=1 and meas_done=1 -> all outputs 0 except sweep_dir=1; release, meas_init rises 11 cycles after the first enable sample (SETTLE 10 + 1).
2. enable=1; meas_dist=123; raise meas_done 20 cycles after meas_init falls -> meas_init high exactly 4 cycles; one res_valid pulse 3-4 cycles after meas_done rises, with res_angle=0, res_dist=123, res_timeout=0; angle becomes 90 next cycle.
3. Respond to every measurement with a done rising edge -> res_angle sequence 0,90,180,90,0,90; sweep_dir goes 0 after the 180 result and 1 after the following 0 result.
4. Never raise meas_done -> res_valid 200-201 cycles after meas_init falls, with res_dist=511, res_timeout=1; sweep continues to angle 90.
5. Drop enable during WAIT, then raise meas_done -> result reported, angle steps to 90, state IDLE (busy=0), meas_init stays 0; re-assert enable -> measurement taken at 90.
6. Assert rst_n=0 during TRIG (meas_init=1) -> meas_init=0, angle=0, busy=0 immediately without waiting for a clk edge; no res_valid is produced.
